// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: round-robin issue of NREQ requesters onto one shared ALU with multi-cycle MUL/DIV and held responses
module alu_issue_ctrl #(
  parameter int BITS       = 8,
  parameter int NREQ       = 4,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BITS-1:0] req_a,
  input  logic [NREQ*BITS-1:0] req_b,
  input  logic [NREQ*BITS-1:0] req_op,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [BITS-1:0]      rsp_z,
  output logic [7:0]           rsp_flags,
  output logic [BITS-1:0]      alu_a,
  output logic [BITS-1:0]      alu_b,
  output logic [BITS-1:0]      alu_op,
  input  logic [BITS-1:0]      alu_z,
  input  logic [7:0]           alu_flags,
  output logic                 busy
);
  localparam int PW   = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int LMAX = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(LMAX + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, grant, g, idx;
  logic [CW-1:0]   cnt, lat;
  logic            found;
  logic [BITS-1:0] a_g, b_g, op_g;

  // scan starting at ptr so the most recently served requester goes last
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

  always_comb begin
    a_g  = '0;
    b_g  = '0;
    op_g = '0;
    for (int i = 0; i < NREQ; i++)
      if (g == PW'(i)) begin
        a_g  = req_a[i*BITS +: BITS];
        b_g  = req_b[i*BITS +: BITS];
        op_g = req_op[i*BITS +: BITS];
      end
    lat = op_g[4:0] == 5'd2 ? CW'(MUL_CYCLES - 1) : op_g[4:0] == 5'd3 ? CW'(DIV_CYCLES - 1) : '0;
  end

  always_comb begin
    state_n = state == IDLE ? (found ? EXEC : IDLE) :
              state == EXEC ? (cnt == '0 ? RESP : EXEC) :
              state == RESP ? (rsp_ready[grant] ? IDLE : RESP) : IDLE;
  end

  assign req_ready = (state == IDLE && found) ? {{(NREQ-1){1'b0}}, 1'b1} << g : '0;
  assign rsp_valid = state == RESP ? {{(NREQ-1){1'b0}}, 1'b1} << grant : '0;
  assign busy      = state != IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_z     <= '0;
      rsp_flags <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        alu_a  <= a_g;
        alu_b  <= b_g;
        alu_op <= op_g;
        grant  <= g;
        cnt    <= lat;
      end
      if (state == EXEC) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          rsp_z     <= alu_z;
          rsp_flags <= alu_flags;
        end
      end
      if (state == RESP && rsp_ready[grant])
        ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scenario tests of alu_issue_ctrl against a stub ALU
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b, req_op;
  logic [7:0]  rsp_z, rsp_flags, alu_a, alu_b, alu_op, alu_z, alu_flags;
  logic        busy;
  logic [8:0]  sum;
  logic [15:0] prod;
  int          nvec = 0;
  int          nerr = 0;

  alu_issue_ctrl #(.BITS(8), .NREQ(4), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
    .alu_flags(alu_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // stub ALU: carry/overflow in flag bit 0, div-by-zero flag 0x10, unknown ops echo op[7:5]
  always_comb begin
    sum  = {1'b0, alu_a} + {1'b0, alu_b};
    prod = alu_a * alu_b;
    alu_z     = alu_a ^ alu_b;
    alu_flags = {alu_op[7:5], 5'b0};
    if (alu_op[4:0] == 5'd0) begin
      alu_z     = sum[7:0];
      alu_flags = {7'b0, sum[8]};
    end else if (alu_op[4:0] == 5'd2) begin
      alu_z     = prod[7:0];
      alu_flags = {7'b0, |prod[15:8]};
    end else if (alu_op[4:0] == 5'd3) begin
      alu_z     = alu_b == 8'h00 ? 8'h00 : alu_a / alu_b;
      alu_flags = alu_b == 8'h00 ? 8'h10 : 8'h00;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic run_op(input int r, input logic [7:0] a, b, op, output int lat,
                        output logic [7:0] z, f, output logic [3:0] rdy, rv);
    @(negedge clk);
    req_valid = 4'b0;
    req_valid[r] = 1'b1;
    req_a[r*8 +: 8] = a;
    req_b[r*8 +: 8] = b;
    req_op[r*8 +: 8] = op;
    #1 rdy = req_ready;
    @(negedge clk);
    req_valid = 4'b0;
    lat = 1;
    while (rsp_valid == 4'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rv = rsp_valid;
    z  = rsp_z;
    f  = rsp_flags;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({busy, req_ready, rsp_valid} !== 9'b0) begin
      nerr++; $display("FAIL reset_ctl: busy/req_ready/rsp_valid=%b required 0", {busy, req_ready, rsp_valid});
    end
    nvec++;
    if ({alu_a, alu_b, alu_op, rsp_z, rsp_flags} !== 40'b0) begin
      nerr++; $display("FAIL reset_data: got %h required 0", {alu_a, alu_b, alu_op, rsp_z, rsp_flags});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat; logic [7:0] z, f; logic [3:0] rdy, rv;
    rsp_ready = '1;
    run_op(0, 8'h10, 8'h22, 8'h00, lat, z, f, rdy, rv);
    nvec++;
    if (rdy !== 4'b0001) begin nerr++; $display("FAIL add_ready: got %b required 0001", rdy); end
    nvec++;
    if (lat !== 2) begin nerr++; $display("FAIL add_latency: got %0d required 2", lat); end
    nvec++;
    if ({rv, z, f} !== {4'b0001, 8'h32, 8'h00}) begin
      nerr++; $display("FAIL add_rsp: got rv=%b z=%h f=%h required 0001 32 00", rv, z, f);
    end
  endtask

  task automatic test_mul_flags();
    int lat; logic [7:0] z, f; logic [3:0] rdy, rv;
    run_op(1, 8'hF0, 8'h20, 8'h00, lat, z, f, rdy, rv);
    nvec++;
    if ({rdy, rv, z, f} !== {4'b0010, 4'b0010, 8'h10, 8'h01}) begin
      nerr++; $display("FAIL add_carry: got rdy=%b rv=%b z=%h f=%h required 0010 0010 10 01", rdy, rv, z, f);
    end
    run_op(1, 8'h10, 8'h10, 8'h02, lat, z, f, rdy, rv);
    nvec++;
    if ({lat, z, f} !== {32'd3, 8'h00, 8'h01}) begin
      nerr++; $display("FAIL mul_ovf: got lat=%0d z=%h f=%h required 3 00 01", lat, z, f);
    end
    run_op(1, 8'h03, 8'h05, 8'h22, lat, z, f, rdy, rv);
    nvec++;
    if ({lat, z, f} !== {32'd3, 8'h0F, 8'h00}) begin
      nerr++; $display("FAIL mul_flagbits: got lat=%0d z=%h f=%h required 3 0f 00", lat, z, f);
    end
    run_op(1, 8'h0F, 8'hF0, 8'h25, lat, z, f, rdy, rv);
    nvec++;
    if ({lat, z, f} !== {32'd2, 8'hFF, 8'h20}) begin
      nerr++; $display("FAIL undef_op: got lat=%0d z=%h f=%h required 2 ff 20", lat, z, f);
    end
  endtask

  task automatic test_div();
    int lat; logic [7:0] z, f; logic [3:0] rdy, rv;
    run_op(2, 8'h09, 8'h00, 8'h03, lat, z, f, rdy, rv);
    nvec++;
    if ({lat, rv, z, f} !== {32'd5, 4'b0100, 8'h00, 8'h10}) begin
      nerr++; $display("FAIL div_zero: got lat=%0d rv=%b z=%h f=%h required 5 0100 00 10", lat, rv, z, f);
    end
    run_op(2, 8'h09, 8'h03, 8'h03, lat, z, f, rdy, rv);
    nvec++;
    if ({lat, z, f} !== {32'd5, 8'h03, 8'h00}) begin
      nerr++; $display("FAIL div: got lat=%0d z=%h f=%h required 5 03 00", lat, z, f);
    end
  endtask

  task automatic test_round_robin();
    int gnt[5] = '{-1, -1, -1, -1, -1};
    int gc[5]  = '{0, 0, 0, 0, 0};
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int exp_d[4] = '{3, 3, 4, 3};
    int n = 0;
    int twohot = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_op = {8'h00, 8'h02, 8'h00, 8'h00};
    req_a = 32'h04030201; req_b = 32'h01010101;
    rsp_ready = '1; req_valid = '1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      #1;
      if ($countones(req_ready) > 1) twohot++;
      if (req_ready != 4'b0) begin gnt[n] = $clog2(req_ready); gc[n] = c; n++; end
      @(negedge clk);
    end
    req_valid = '0;
    nvec++;
    if (twohot !== 0) begin nerr++; $display("FAIL rr_onehot: %0d multi-hot cycles required 0", twohot); end
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (gnt[i] !== exp_g[i]) begin nerr++; $display("FAIL rr_order[%0d]: got %0d required %0d", i, gnt[i], exp_g[i]); end
    end
    for (int i = 1; i < 5; i++) begin
      nvec++;
      if (gc[i] - gc[i-1] !== exp_d[i-1]) begin
        nerr++; $display("FAIL rr_interval[%0d]: got %0d required %0d", i, gc[i] - gc[i-1], exp_d[i-1]);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] z, f; logic [3:0] rdy, rv;
    int bad = 0;
    rsp_ready = '0;
    run_op(3, 8'h01, 8'h02, 8'h00, lat, z, f, rdy, rv);
    nvec++;
    if ({rdy, rv, z} !== {4'b1000, 4'b1000, 8'h03}) begin
      nerr++; $display("FAIL bp_first: got rdy=%b rv=%b z=%h required 1000 1000 03", rdy, rv, z);
    end
    req_valid = 4'b0111; rsp_ready = 4'b0111;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid !== 4'b1000 || rsp_z !== 8'h03 || req_ready !== 4'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    nvec++;
    if (bad !== 0) begin nerr++; $display("FAIL bp_hold: %0d unstable cycles required 0", bad); end
    rsp_ready = 4'b1000;
    @(negedge clk);
    #1;
    nvec++;
    if ({rsp_valid, req_ready} !== {4'b0000, 4'b0001}) begin
      nerr++; $display("FAIL bp_release: got rv=%b rdy=%b required 0000 0001", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = '0; rsp_ready = '1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat; logic [7:0] z, f; logic [3:0] rdy, rv;
    int bad = 0;
    req_valid = 4'b0001; req_a[7:0] = 8'h09; req_b[7:0] = 8'h03; req_op[7:0] = 8'h03;
    @(negedge clk);
    req_valid = '0;
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL abort_exec: busy=%b required 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if ({busy, rsp_valid, req_ready, alu_a, alu_op, rsp_z, rsp_flags} !== 41'b0) begin
      nerr++; $display("FAIL abort_clear: got %h required 0", {busy, rsp_valid, req_ready, alu_a, alu_op, rsp_z, rsp_flags});
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0 || busy !== 1'b0) bad++;
    end
    nvec++;
    if (bad !== 0) begin nerr++; $display("FAIL abort_norsp: %0d active cycles required 0", bad); end
    run_op(2, 8'h07, 8'h03, 8'h00, lat, z, f, rdy, rv);
    nvec++;
    if ({rdy, lat, rv, z} !== {4'b0100, 32'd2, 4'b0100, 8'h0A}) begin
      nerr++; $display("FAIL abort_next: got rdy=%b lat=%0d rv=%b z=%h required 0100 2 0100 0a", rdy, lat, rv, z);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_flags();
    test_div();
    test_round_robin();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
